// File: rtl/ram_stream_reader.sv
// ============================================================================
// ram_stream_reader : sweeps a RAM address window out as a valid/ready stream
//   with a last marker. Optional macro RAM_STREAM_STALL_CNT_EN adds the
//   stall_cycles output.
// Rev 1.0
// ============================================================================
`default_nettype none

module ram_stream_reader #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 12,
    parameter int MEM_DEPTH     = 2500,
    parameter int LEN_WIDTH     = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]     length,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [ADDRESS_WIDTH-1:0] ram_addr,
    output logic                     ram_we,
    input  logic [DATA_WIDTH-1:0]    ram_rdata,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_valid,
    output logic                     out_last,
    input  logic                     out_ready
`ifdef RAM_STREAM_STALL_CNT_EN
    ,
    output logic [15:0]              stall_cycles
`endif
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam int         c_EXT_WIDTH = ADDRESS_WIDTH + 1;

    logic [1:0]               r_state;
    logic [1:0]               w_next_state;
    logic [ADDRESS_WIDTH-1:0] r_base;
    logic [ADDRESS_WIDTH-1:0] r_addr_hold;
    logic [LEN_WIDTH-1:0]     r_len;
    logic [LEN_WIDTH-1:0]     r_issued;
    logic                     r_inflight;
    logic                     r_inflight_last;
    logic [DATA_WIDTH-1:0]    r_data0;
    logic [DATA_WIDTH-1:0]    r_data1;
    logic                     r_last0;
    logic                     r_last1;
    logic [1:0]               r_count;
    logic                     r_err;
    logic                     r_zero_done;

    logic                     w_pop;
    logic                     w_push;
    logic                     w_issue;
    logic                     w_issue_last;
    logic                     w_final_pop;
    logic                     w_cmd_zero;
    logic                     w_cmd_oob;
    logic                     w_accept;
    logic [c_EXT_WIDTH-1:0]   w_end;
    logic [2:0]               w_credit;

    // Window end computed one bit wider so base+length cannot wrap.
    assign w_end      = c_EXT_WIDTH'(base_addr) + c_EXT_WIDTH'(length);
    assign w_cmd_zero = (length == '0);
    assign w_cmd_oob  = (w_end > c_EXT_WIDTH'(MEM_DEPTH));
    assign w_accept   = (r_state == c_IDLE) && start && !w_cmd_zero && !w_cmd_oob;

    assign out_valid    = (r_count != 2'd0);
    assign out_data     = r_data0;
    assign out_last     = out_valid && r_last0;
    assign w_pop        = out_valid && out_ready;
    assign w_push       = r_inflight;
    assign w_credit     = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue_last = (r_issued == (r_len - LEN_WIDTH'(1)));
    assign ram_we       = 1'b0;
    assign err          = r_err;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (w_accept) w_next_state = c_ISSUE;
            c_ISSUE: if (w_issue && w_issue_last) w_next_state = c_DRAIN;
            c_DRAIN: if (w_final_pop) w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // Output logic: issue decision, address, completion
    always_comb begin
        w_issue     = 1'b0;
        w_final_pop = 1'b0;
        busy        = (r_state != c_IDLE);
        ram_addr    = r_addr_hold;
        if ((r_state == c_ISSUE) && (r_issued < r_len) && (w_credit < 3'd2)) begin
            w_issue  = 1'b1;
            ram_addr = r_base + ADDRESS_WIDTH'(r_issued);
        end
        if ((r_state == c_DRAIN) && w_pop && r_last0) begin
            w_final_pop = 1'b1;
        end
        done = r_zero_done || w_final_pop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_base          <= '0;
            r_addr_hold     <= '0;
            r_len           <= '0;
            r_issued        <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_data0         <= '0;
            r_data1         <= '0;
            r_last0         <= 1'b0;
            r_last1         <= 1'b0;
            r_count         <= 2'd0;
            r_err           <= 1'b0;
            r_zero_done     <= 1'b0;
        end else begin
            r_err       <= (r_state == c_IDLE) && start && !w_cmd_zero && w_cmd_oob;
            r_zero_done <= (r_state == c_IDLE) && start && w_cmd_zero;
            if (w_accept) begin
                r_base   <= base_addr;
                r_len    <= length;
                r_issued <= '0;
            end else if (w_issue) begin
                r_issued    <= r_issued + LEN_WIDTH'(1);
                r_addr_hold <= ram_addr;
            end
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && w_issue_last;

            // Two-entry shift FIFO; the credit rule keeps a push off a full buffer.
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_data0 <= ram_rdata;
                        r_last0 <= r_inflight_last;
                    end else begin
                        r_data1 <= ram_rdata;
                        r_last1 <= r_inflight_last;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_data0 <= r_data1;
                    r_last0 <= r_last1;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_data0 <= ram_rdata;
                        r_last0 <= r_inflight_last;
                    end else begin
                        r_data0 <= r_data1;
                        r_last0 <= r_last1;
                        r_data1 <= ram_rdata;
                        r_last1 <= r_inflight_last;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef RAM_STREAM_STALL_CNT_EN
    logic [15:0] r_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall <= '0;
        end else if (w_accept) begin
            r_stall <= '0;
        end else if (busy && out_valid && !out_ready && (r_stall != 16'hFFFF)) begin
            r_stall <= r_stall + 16'd1;
        end
    end

    assign stall_cycles = r_stall;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ram_stream_reader.sv
// Self-checking bench for ram_stream_reader: RAM model plus expected-word model.
`default_nettype none

module tb_ram_stream_reader;
    localparam int DW = 16;
    localparam int AW = 12;
    localparam int LW = 12;
    localparam int DEPTH = 2500;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [LW-1:0] length;
    logic          busy, done, err, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_rdata;
    logic [DW-1:0] out_data;
    logic          out_valid, out_last, out_ready;
`ifdef RAM_STREAM_STALL_CNT_EN
    logic [15:0]   stall_cycles;
`endif

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem [DEPTH];
    int pat [6] = '{1, 0, 0, 1, 0, 1};

    always #5 clk = ~clk;

    always @(posedge clk)
        ram_rdata <= (int'(ram_addr) < DEPTH) ? mem[ram_addr] : 16'hDEAD;

    ram_stream_reader dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
        .busy(busy), .done(done), .err(err), .ram_addr(ram_addr), .ram_we(ram_we),
        .ram_rdata(ram_rdata), .out_data(out_data), .out_valid(out_valid),
        .out_last(out_last), .out_ready(out_ready)
`ifdef RAM_STREAM_STALL_CNT_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transfer of n words from base b; expected words come from mem[b..b+n-1].
    // mode 0: ready high, 1: fixed toggle pattern, 2: random ready.
    task automatic run_xfer(input int b, input int n, input int mode, input bit poke);
        int got = 0;
        int cyc = 1;
        int stalls = 0;
        int first_valid = -1;
        bit done_seen = 0;
        bit prev_stall = 0;
        logic [DW-1:0] prev_d = '0;
        logic prev_last = 1'b0;
        base_addr = AW'(b);
        length    = LW'(n);
        start     = 1'b1;
        tick();
        start = 1'b0;
        while (!done_seen && cyc < 300) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (pat[(cyc - 1) % 6] != 0);
                default: out_ready = ($urandom_range(0, 1) == 1);
            endcase
            if (poke && cyc == 2) begin
                start = 1'b1; base_addr = 12'd500; length = 12'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            chk("ram_we", ram_we, 0);
            chk("busy_during", busy, 1);
            if (cyc == 1) chk("first_addr", ram_addr, b);
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, prev_d);
                chk("hold_last", out_last, prev_last);
            end
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (out_valid && out_ready) begin
                chk("data", out_data, mem[b + got]);
                chk("last", out_last, (got == n - 1));
                chk("done_hs", done, (got == n - 1));
                got++;
                if (got == n) done_seen = 1;
            end else begin
                if (out_valid) stalls++;
                chk("no_done", done, 0);
            end
            prev_stall = out_valid && !out_ready;
            prev_d     = out_data;
            prev_last  = out_last;
            tick();
            cyc++;
        end
        start = 1'b0;
        chk("done_seen", done_seen, 1);
        chk("word_count", got, n);
        if (mode == 0) chk("latency", first_valid, 3);
        @(negedge clk);
        chk("busy_after", busy, 0);
        chk("done_after", done, 0);
        chk("valid_after", out_valid, 0);
`ifdef RAM_STREAM_STALL_CNT_EN
        chk("stall_cycles", stall_cycles, stalls);
`endif
        tick();
        out_ready = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] a;
        int got;
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
        rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; out_ready = 1'b1;
        tick(); tick();
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_data", out_data, 0);
        chk("rst_we", ram_we, 0);
        tick();
        rst = 1'b0;
        tick();

        run_xfer(0, 4, 0, 0);
        run_xfer(100, 6, 1, 0);
        run_xfer(2496, 4, 0, 0);

        // Out-of-range window
        base_addr = 12'd2497; length = 12'd4; start = 1'b1;
        tick(); start = 1'b0;
        @(negedge clk);
        chk("oob_err", err, 1);
        chk("oob_busy", busy, 0);
        chk("oob_valid", out_valid, 0);
        tick();
        @(negedge clk);
        chk("oob_err_clr", err, 0);
        chk("oob_busy2", busy, 0);
        chk("oob_valid2", out_valid, 0);
        tick();

        // Zero length
        a = ram_addr;
        base_addr = 12'd7; length = 12'd0; start = 1'b1;
        tick(); start = 1'b0;
        @(negedge clk);
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        chk("zero_err", err, 0);
        chk("zero_addr", ram_addr, a);
        tick();
        @(negedge clk);
        chk("zero_done_clr", done, 0);
        chk("zero_busy2", busy, 0);
        chk("zero_valid", out_valid, 0);
        chk("zero_addr2", ram_addr, a);
        tick();

        // Start while busy is ignored
        run_xfer(40, 8, 2, 1);

        // Reset after two of ten words
        base_addr = 12'd0; length = 12'd10; start = 1'b1; out_ready = 1'b1;
        tick(); start = 1'b0;
        got = 0;
        for (int c = 0; c < 20 && got < 2; c++) begin
            @(negedge clk);
            if (out_valid && out_ready) got++;
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_err", err, 0);
        chk("mrst_valid", out_valid, 0);
        chk("mrst_last", out_last, 0);
        chk("mrst_data", out_data, 0);
        chk("mrst_addr", ram_addr, 0);
        tick();
        @(negedge clk);
        chk("mrst_done2", done, 0);
        chk("mrst_valid2", out_valid, 0);
        tick();
        run_xfer(0, 2, 0, 0);

        // Random windows with random backpressure
        for (int t = 0; t < 6; t++) begin
            int n;
            int b;
            n = $urandom_range(1, 20);
            b = $urandom_range(0, DEPTH - n);
            run_xfer(b, n, 2, 0);
        end
        run_xfer(DEPTH - 3, 3, 2, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
